mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- MEM stage of the 5-stage RV32 pipeline. Sits between the EX/MEM register (execute-stage outputs) and writeback.
- Performs loads and stores over a req/ack data-memory port that may take several cycles. Handles byte enables and store-data replication, and sign/zero-extends load data.
- Raises a stall to the hazard unit while an access is outstanding. Owns the MEM/WB pipeline register.

Parameters:
ADDR_W, 32, data-memory byte-address width; must be ≤32. dmem_addr = ALUresM[ADDR_W-1:2] concatenated with 2'b00.

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
regwriteM  input  1  register-file write enable from EX/MEM
memrwM  input  1  1 = store
wbselM  input  2  00 ALU, 01 load data, 10 pc+4; 01 marks a load
funct3M  input  3  access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU)
rdM  input  5  destination register
ALUresM  input  32  effective address / ALU result
data_writeM  input  32  store data
pc4M  input  32  pc+4
dmem_req  output  1  access request
dmem_we  output  1  write enable
dmem_addr  output  ADDR_W  word-aligned address
dmem_be  output  4  byte enables
dmem_wdata  output  32  replicated store data
dmem_ack  input  1  access complete; rdata valid this cycle for loads
dmem_rdata  input  32  read word
stall_mem  output  1  freeze PC, IF/ID, ID/EX and EX/MEM
regwriteW  output  1  to WB
wbselW  output  2  to WB
rdW  output  5  to WB
ALUresW  output  32  to WB
readdataW  output  32  extended load data
pc4W  output  32  to WB

Behaviour:
- memop = memrwM | (wbselM==01). Loads and stores are never both asserted.
- FSM states: IDLE, WAIT.
  - IDLE → WAIT when memop & ~dmem_ack.
  - WAIT → IDLE when dmem_ack.
- dmem_req = memop in IDLE; 1 in WAIT. dmem_we = memrwM.
- dmem_addr, dmem_be, dmem_wdata are combinational from the held EX/MEM inputs. They stay stable while req is high because the stall freezes EX/MEM.
- stall_mem = memop & ~dmem_ack, combinational in both states. A zero-wait memory (ack in the same cycle as req) causes no stall.
- Byte enables and store data, with off = ALUresM[1:0]:
  - SB: be = 4'b0001<<off; wdata = {4{data_writeM[7:0]}}.
  - SH: be = off[1] ? 1100 : 0011; wdata = {2{data_writeM[15:0]}}.
  - SW: be = 1111; wdata = data_writeM.
  - Loads drive be = 1111.
- Load extraction is from dmem_rdata at the ack cycle, using off:
  - B/BU select byte off; H/HU select half off[1]; W takes the full word.
  - B and H sign-extend; BU and HU zero-extend.
  - Undefined funct3 values behave as W.
- MEM/WB register, clocked on posedge clk:
  - If stall_mem: capture a bubble (regwriteW=0, wbselW=00, all other fields 0). WB must never write twice for one instruction.
  - Otherwise: capture all fields. readdataW = extended data for loads, 0 for non-loads.
- Latency: 1 cycle from ack, or from a non-memory instruction, to the W outputs.
- Reset: every output register is 0 and the state is IDLE. Reset asserted mid-access drops dmem_req immediately, because memop depends on the EX/MEM register, which also resets.
- Non-memory instructions never assert dmem_req.
- ack arriving in WAIT on the same cycle the hazard unit would flush is not this block's concern. EX/MEM is frozen during the stall, so a flush cannot occur then.

Optional Feature:
MEM_MISALIGN_TRAP_EN
- Defined:
  - A misaligned access is detected: H/HU/SH with off[0]=1, or W/SW with off≠00.
  - On detection: no dmem_req, no stall. The next cycle has regwriteW=0 and an added output misalignW=1 for that one cycle.
- Undefined:
  - No misalignW port. Low address bits beyond the size are ignored for lane selection (H uses off[1], W uses lane 0).

Test Plan:
- SW addr 0x100, data 0xDEADBEEF, ack same cycle → req=1, be=1111, stall_mem never high, next cycle regwriteW as given.
- SB addr 0x103, data 0x000000A5 → be=1000, wdata=0xA5A5A5A5.
- LB addr 0x202, rdata 0x0080FF00, ack after 3 cycles → stall_mem high 3 cycles, bubbles in WB, then readdataW=0xFFFFFF80.
- LHU addr 0x202, rdata 0x8001_0000, zero wait → readdataW=0x00008001; LH on the same data gives 0xFFFF8001.
- Reset asserted during WAIT → dmem_req drops in the same cycle, all W outputs 0, state IDLE after release.
- With MEM_MISALIGN_TRAP_EN: LW addr 0x101 → no req, misalignW=1 for 1 cycle, regwriteW=0.

Source files
------------

// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage (master) and
// the data memory (slave). Address is a word-aligned byte address.
interface mem_stage_if #(
  parameter int ADDR_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [3:0]        be;
  logic [31:0]       wdata;
  logic              ack;
  logic [31:0]       rdata;

  modport master (
    output req, we, addr, be, wdata,
    input  ack, rdata
  );

  modport slave (
    input  req, we, addr, be, wdata,
    output ack, rdata
  );
endinterface

// File: rtl/mem_stage.sv
// MEM stage of the 5-stage RV32 pipeline: issues loads/stores on a req/ack
// data-memory bus, stalls the front of the pipe while an access is pending,
// extends load data and owns the MEM/WB pipeline register.
// Optional build macro MEM_MISALIGN_TRAP_EN: misaligned H/W accesses are
// suppressed (no request, no write-back) and flagged on misalignW.
module mem_stage #(
  parameter int ADDR_W = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        regwriteM,
  input  logic        memrwM,
  input  logic [1:0]  wbselM,
  input  logic [2:0]  funct3M,
  input  logic [4:0]  rdM,
  input  logic [31:0] ALUresM,
  input  logic [31:0] data_writeM,
  input  logic [31:0] pc4M,
  mem_stage_if.master dmem,
  output logic        stall_mem,
  output logic        regwriteW,
  output logic [1:0]  wbselW,
  output logic [4:0]  rdW,
  output logic [31:0] ALUresW,
  output logic [31:0] readdataW,
  output logic [31:0] pc4W
`ifdef MEM_MISALIGN_TRAP_EN
 ,output logic        misalignW
`endif
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t      state_reg;
  state_t      state_next;
  logic [1:0]  off;
  logic        is_load;
  logic        memop_raw;
  logic        memop;
  logic        req_next;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;

  // funct3[1:0]: 00 byte, 01 half, anything else is treated as a word;
  // funct3[2] selects zero-extension for loads.
  assign off       = ALUresM[1:0];
  assign is_load   = (wbselM == 2'b01);
  assign memop_raw = memrwM | is_load;

`ifdef MEM_MISALIGN_TRAP_EN
  logic misalign;

  // Flag halfword accesses on odd addresses and word accesses off lane 0.
  always_comb begin
    misalign = 1'b0;
    if (memop_raw) begin
      case (funct3M[1:0])
        2'b00:   misalign = 1'b0;
        2'b01:   misalign = off[0];
        default: misalign = (off != 2'b00);
      endcase
    end
  end

  assign memop = memop_raw & ~misalign;
`else
  assign memop = memop_raw;
`endif

  // Hold the stall until the memory acknowledges; zero-wait memory never stalls.
  assign stall_mem = memop & ~dmem.ack;

  // Access state register; async reset returns to IDLE so req drops at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and request generation.
  always_comb begin
    state_next = state_reg;
    req_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        req_next = memop;
        if (memop && !dmem.ack) state_next = WAIT;
      end
      WAIT: begin
        req_next = 1'b1;
        if (dmem.ack) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Byte lanes and replicated store data; loads always read the full word.
  always_comb begin
    be_next    = 4'b1111;
    wdata_next = data_writeM;
    if (memrwM) begin
      case (funct3M[1:0])
        2'b00: begin
          be_next    = 4'b0001 << off;
          wdata_next = {4{data_writeM[7:0]}};
        end
        2'b01: begin
          be_next    = off[1] ? 4'b1100 : 4'b0011;
          wdata_next = {2{data_writeM[15:0]}};
        end
        default: begin
          be_next    = 4'b1111;
          wdata_next = data_writeM;
        end
      endcase
    end
  end

  assign dmem.req   = req_next;
  assign dmem.we    = memrwM;
  assign dmem.addr  = {ALUresM[ADDR_W-1:2], 2'b00};
  assign dmem.be    = be_next;
  assign dmem.wdata = wdata_next;

  // Select the addressed lane of the read word and sign/zero-extend it.
  always_comb begin
    byte_sel = dmem.rdata[7:0];
    case (off)
      2'b00: byte_sel = dmem.rdata[7:0];
      2'b01: byte_sel = dmem.rdata[15:8];
      2'b10: byte_sel = dmem.rdata[23:16];
      2'b11: byte_sel = dmem.rdata[31:24];
      default: byte_sel = dmem.rdata[7:0];
    endcase
    half_sel = off[1] ? dmem.rdata[31:16] : dmem.rdata[15:0];
    case (funct3M[1:0])
      2'b00:   load_ext = {{24{~funct3M[2] & byte_sel[7]}}, byte_sel};
      2'b01:   load_ext = {{16{~funct3M[2] & half_sel[15]}}, half_sel};
      default: load_ext = dmem.rdata;
    endcase
  end

  // MEM/WB register: a stalled cycle inserts a bubble so WB writes exactly once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regwriteW <= 1'b0;
      wbselW    <= 2'b00;
      rdW       <= 5'd0;
      ALUresW   <= 32'd0;
      readdataW <= 32'd0;
      pc4W      <= 32'd0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalignW <= 1'b0;
`endif
    end else if (stall_mem) begin
      regwriteW <= 1'b0;
      wbselW    <= 2'b00;
      rdW       <= 5'd0;
      ALUresW   <= 32'd0;
      readdataW <= 32'd0;
      pc4W      <= 32'd0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalignW <= 1'b0;
`endif
    end else begin
      wbselW    <= wbselM;
      rdW       <= rdM;
      ALUresW   <= ALUresM;
      pc4W      <= pc4M;
`ifdef MEM_MISALIGN_TRAP_EN
      regwriteW <= regwriteM & ~misalign;
      readdataW <= (is_load && !misalign) ? load_ext : 32'd0;
      misalignW <= misalign;
`else
      regwriteW <= regwriteM;
      readdataW <= is_load ? load_ext : 32'd0;
`endif
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: expected MEM/WB contents are queued when
// an instruction is presented and popped when the stage retires it.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        regwriteM;
  logic        memrwM;
  logic [1:0]  wbselM;
  logic [2:0]  funct3M;
  logic [4:0]  rdM;
  logic [31:0] ALUresM;
  logic [31:0] data_writeM;
  logic [31:0] pc4M;
  logic        stall_mem;
  logic        regwriteW;
  logic [1:0]  wbselW;
  logic [4:0]  rdW;
  logic [31:0] ALUresW;
  logic [31:0] readdataW;
  logic [31:0] pc4W;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalignW;
`endif

  always #5 clk = ~clk;

  mem_stage_if #(.ADDR_W(32)) dmem ();

  mem_stage #(.ADDR_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .regwriteM  (regwriteM),
    .memrwM     (memrwM),
    .wbselM     (wbselM),
    .funct3M    (funct3M),
    .rdM        (rdM),
    .ALUresM    (ALUresM),
    .data_writeM(data_writeM),
    .pc4M       (pc4M),
    .dmem       (dmem.master),
    .stall_mem  (stall_mem),
    .regwriteW  (regwriteW),
    .wbselW     (wbselW),
    .rdW        (rdW),
    .ALUresW    (ALUresW),
    .readdataW  (readdataW),
    .pc4W       (pc4W)
`ifdef MEM_MISALIGN_TRAP_EN
   ,.misalignW  (misalignW)
`endif
  );

  typedef struct packed {
    logic        regwrite;
    logic [1:0]  wbsel;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [31:0] pc4;
  } wb_t;

  wb_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;

  task automatic drive_nop();
    regwriteM   = 1'b0;
    memrwM      = 1'b0;
    wbselM      = 2'b00;
    funct3M     = 3'b000;
    rdM         = 5'd0;
    ALUresM     = 32'd0;
    data_writeM = 32'd0;
    pc4M        = 32'd0;
    dmem.ack    = 1'b0;
    dmem.rdata  = 32'd0;
  endtask

  // Present one instruction (called at posedge+1), answer it after 'delay'
  // wait cycles, and compare bus, stall and MEM/WB results.
  task automatic run_instr(input string name, input logic rw, input logic mrw,
                           input logic [1:0] wb, input logic [2:0] f3, input logic [4:0] rd,
                           input logic [31:0] alu, input logic [31:0] wd, input logic [31:0] pc4,
                           input int delay, input logic [31:0] rdata,
                           input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                           input logic [31:0] exp_rdata);
    logic  memop;
    int    stalls;
    wb_t   e;
    wb_t   got;
    memop       = mrw | (wb == 2'b01);
    regwriteM   = rw;
    memrwM      = mrw;
    wbselM      = wb;
    funct3M     = f3;
    rdM         = rd;
    ALUresM     = alu;
    data_writeM = wd;
    pc4M        = pc4;
    dmem.rdata  = rdata;
    exp_q.push_back({rw, wb, rd, alu, (wb == 2'b01) ? exp_rdata : 32'd0, pc4});
    stalls = 0;
    for (int c = 0; c <= delay; c++) begin
      dmem.ack = memop && (c == delay);
      @(negedge clk);
      checks++;
      if (dmem.req !== memop) begin
        failures++;
        $display("FAIL %s req: got %b exp %b (cycle %0d)", name, dmem.req, memop, c);
      end
      if (memop) begin
        checks++;
        if (dmem.we !== mrw || dmem.addr !== {alu[31:2], 2'b00} || dmem.be !== exp_be) begin
          failures++;
          $display("FAIL %s bus: got we=%b addr=%h be=%b exp we=%b addr=%h be=%b",
                   name, dmem.we, dmem.addr, dmem.be, mrw, {alu[31:2], 2'b00}, exp_be);
        end
        if (mrw) begin
          checks++;
          if (dmem.wdata !== exp_wdata) begin
            failures++;
            $display("FAIL %s wdata: got %h exp %h", name, dmem.wdata, exp_wdata);
          end
        end
      end
      if (stall_mem === 1'b1) stalls++;
      checks++;
      if (stall_mem !== (memop && (c < delay))) begin
        failures++;
        $display("FAIL %s stall: got %b exp %b (cycle %0d)", name, stall_mem, memop && (c < delay), c);
      end
      @(posedge clk);
      #1;
      if (c < delay) begin
        checks++;
        if ({regwriteW, wbselW, rdW, ALUresW, readdataW, pc4W} !== '0) begin
          failures++;
          $display("FAIL %s bubble: got rw=%b wb=%b rd=%0d alu=%h rdat=%h pc4=%h exp all zero",
                   name, regwriteW, wbselW, rdW, ALUresW, readdataW, pc4W);
        end
      end
    end
    dmem.ack = 1'b0;
    checks++;
    if (stalls != (memop ? delay : 0)) begin
      failures++;
      $display("FAIL %s stall_count: got %0d exp %0d", name, stalls, memop ? delay : 0);
    end
    e   = exp_q.pop_front();
    got = {regwriteW, wbselW, rdW, ALUresW, readdataW, pc4W};
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL %s wb: got rw=%b wb=%b rd=%0d alu=%h rdat=%h pc4=%h exp rw=%b wb=%b rd=%0d alu=%h rdat=%h pc4=%h",
               name, regwriteW, wbselW, rdW, ALUresW, readdataW, pc4W,
               e.regwrite, e.wbsel, e.rd, e.alu, e.rdata, e.pc4);
    end
    $display("txn %-12s alu=%h stalls=%0d readdataW=%h regwriteW=%b", name, alu, stalls, readdataW, regwriteW);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_nop();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({dmem.req, stall_mem, regwriteW, wbselW, rdW, ALUresW, readdataW, pc4W} !== '0) begin
      failures++;
      $display("FAIL reset_state: got req=%b stall=%b rw=%b wb=%b rd=%0d alu=%h rdat=%h pc4=%h exp all zero",
               dmem.req, stall_mem, regwriteW, wbselW, rdW, ALUresW, readdataW, pc4W);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    $display("txn reset       outputs checked");
  endtask

  task automatic test_store();
    run_instr("sw_0x100", 1'b0, 1'b1, 2'b00, 3'b010, 5'd5, 32'h100, 32'hDEADBEEF, 32'h1004, 0, 32'h0,
              4'b1111, 32'hDEADBEEF, 32'h0);
    run_instr("sb_0x103", 1'b0, 1'b1, 2'b00, 3'b000, 5'd0, 32'h103, 32'h000000A5, 32'h1008, 1, 32'h0,
              4'b1000, 32'hA5A5A5A5, 32'h0);
    run_instr("sh_0x102", 1'b0, 1'b1, 2'b00, 3'b001, 5'd0, 32'h102, 32'h00001234, 32'h100C, 0, 32'h0,
              4'b1100, 32'h12341234, 32'h0);
    run_instr("sh_0x100", 1'b0, 1'b1, 2'b00, 3'b001, 5'd0, 32'h100, 32'hFFFFABCD, 32'h1010, 2, 32'h0,
              4'b0011, 32'hABCDABCD, 32'h0);
    run_instr("sb_0x101", 1'b0, 1'b1, 2'b00, 3'b000, 5'd0, 32'h101, 32'h12345677, 32'h1014, 0, 32'h0,
              4'b0010, 32'h77777777, 32'h0);
  endtask

  task automatic test_load();
    run_instr("lb_0x202", 1'b1, 1'b0, 2'b01, 3'b000, 5'd7, 32'h202, 32'h0, 32'h2004, 3, 32'h0080FF00,
              4'b1111, 32'h0, 32'hFFFFFF80);
    run_instr("lhu_0x202", 1'b1, 1'b0, 2'b01, 3'b101, 5'd8, 32'h202, 32'h0, 32'h2008, 0, 32'h80010000,
              4'b1111, 32'h0, 32'h00008001);
    run_instr("lh_0x202", 1'b1, 1'b0, 2'b01, 3'b001, 5'd9, 32'h202, 32'h0, 32'h200C, 0, 32'h80010000,
              4'b1111, 32'h0, 32'hFFFF8001);
    run_instr("lbu_0x201", 1'b1, 1'b0, 2'b01, 3'b100, 5'd10, 32'h201, 32'h0, 32'h2010, 0, 32'h0000FF00,
              4'b1111, 32'h0, 32'h000000FF);
    run_instr("lb_0x203", 1'b1, 1'b0, 2'b01, 3'b000, 5'd11, 32'h203, 32'h0, 32'h2014, 1, 32'h7F000000,
              4'b1111, 32'h0, 32'h0000007F);
    run_instr("lh_0x200", 1'b1, 1'b0, 2'b01, 3'b001, 5'd12, 32'h200, 32'h0, 32'h2018, 0, 32'hFFFF7FFF,
              4'b1111, 32'h0, 32'h00007FFF);
    run_instr("lw_0x300", 1'b1, 1'b0, 2'b01, 3'b010, 5'd13, 32'h300, 32'h0, 32'h201C, 1, 32'h12345678,
              4'b1111, 32'h0, 32'h12345678);
    run_instr("ld_f3_011", 1'b1, 1'b0, 2'b01, 3'b011, 5'd14, 32'h304, 32'h0, 32'h2020, 0, 32'hCAFEF00D,
              4'b1111, 32'h0, 32'hCAFEF00D);
  endtask

  task automatic test_nonmem();
    run_instr("alu_op", 1'b1, 1'b0, 2'b00, 3'b000, 5'd3, 32'h00000055, 32'h1111, 32'h3004, 0, 32'hFFFFFFFF,
              4'b1111, 32'h0, 32'h0);
    run_instr("jal_op", 1'b1, 1'b0, 2'b10, 3'b000, 5'd1, 32'h00000800, 32'h0, 32'h3008, 0, 32'hFFFFFFFF,
              4'b1111, 32'h0, 32'h0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    logic [31:0] r;
    for (int i = 0; i < 8; i++) begin
      a = {$urandom_range(0, 32'hFFFF), 2'b00};
      r = $urandom;
      if (i % 2 == 0)
        run_instr("b2b_lw", 1'b1, 1'b0, 2'b01, 3'b010, 5'(i + 16), a, 32'h0, 32'h4000 + a, 0, r,
                  4'b1111, 32'h0, r);
      else
        run_instr("b2b_alu", 1'b1, 1'b0, 2'b00, 3'b000, 5'(i + 16), a, r, 32'h4000 + a, 0, r,
                  4'b1111, 32'h0, 32'h0);
    end
  endtask

`ifdef MEM_MISALIGN_TRAP_EN
  task automatic test_misalign();
    regwriteM   = 1'b1;
    memrwM      = 1'b0;
    wbselM      = 2'b01;
    funct3M     = 3'b010;
    rdM         = 5'd6;
    ALUresM     = 32'h101;
    data_writeM = 32'h0;
    pc4M        = 32'h5004;
    dmem.ack    = 1'b0;
    dmem.rdata  = 32'h11223344;
    @(negedge clk);
    checks++;
    if (dmem.req !== 1'b0 || stall_mem !== 1'b0) begin
      failures++;
      $display("FAIL misalign_req: got req=%b stall=%b exp 0 0", dmem.req, stall_mem);
    end
    @(posedge clk);
    #1;
    checks++;
    if (regwriteW !== 1'b0 || misalignW !== 1'b1) begin
      failures++;
      $display("FAIL misalign_wb: got rw=%b misalignW=%b exp 0 1", regwriteW, misalignW);
    end
    $display("txn lw_0x101    trapped misalignW=%b", misalignW);
    run_instr("after_trap", 1'b1, 1'b0, 2'b00, 3'b000, 5'd2, 32'h77, 32'h0, 32'h5008, 0, 32'h0,
              4'b1111, 32'h0, 32'h0);
    checks++;
    if (misalignW !== 1'b0) begin
      failures++;
      $display("FAIL misalign_clear: got %b exp 0", misalignW);
    end
  endtask
`else
  task automatic test_misalign();
    run_instr("lw_0x101", 1'b1, 1'b0, 2'b01, 3'b010, 5'd6, 32'h101, 32'h0, 32'h5004, 0, 32'h11223344,
              4'b1111, 32'h0, 32'h11223344);
    run_instr("lh_0x203", 1'b1, 1'b0, 2'b01, 3'b001, 5'd6, 32'h203, 32'h0, 32'h5008, 1, 32'h80015555,
              4'b1111, 32'h0, 32'hFFFF8001);
  endtask
`endif

  task automatic test_reset_in_wait();
    regwriteM   = 1'b1;
    memrwM      = 1'b0;
    wbselM      = 2'b01;
    funct3M     = 3'b010;
    rdM         = 5'd4;
    ALUresM     = 32'h400;
    data_writeM = 32'h0;
    pc4M        = 32'h6004;
    dmem.ack    = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (dmem.req !== 1'b1 || stall_mem !== 1'b1) begin
      failures++;
      $display("FAIL wait_req: got req=%b stall=%b exp 1 1", dmem.req, stall_mem);
    end
    #1;
    rst_n = 1'b0;
    drive_nop();
    #1;
    checks++;
    if ({dmem.req, stall_mem, regwriteW, wbselW, rdW, ALUresW, readdataW, pc4W} !== '0) begin
      failures++;
      $display("FAIL reset_in_wait: got req=%b stall=%b rw=%b alu=%h pc4=%h exp all zero",
               dmem.req, stall_mem, regwriteW, ALUresW, pc4W);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (dmem.req !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset: got req=%b exp 0", dmem.req);
    end
    @(posedge clk);
    #1;
    $display("txn reset_wait  req dropped, idle after release");
    run_instr("post_reset", 1'b1, 1'b0, 2'b01, 3'b000, 5'd15, 32'h401, 32'h0, 32'h6008, 0, 32'h0000A500,
              4'b1111, 32'h0, 32'hFFFFFFA5);
  endtask

  initial begin
    test_reset();
    test_store();
    test_load();
    test_nonmem();
    test_back_to_back();
    test_misalign();
    test_reset_in_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
